cache_mem_arbiter: RTL

- Shares one cache-line memory port between two blocking caches: requester 0 is the instruction cache, requester 1 is the data cache.
- Sits between the two cache controllers' memreq/memresp val/rdy interfaces and the single test memory port.
- Allows exactly one transaction in flight, using round-robin arbitration.
- Registers each request, routes the memory response back to the requester that issued it, and never reorders traffic.

---
 rtl/cache_mem_arb_pkg.sv | 17 +
 rtl/cache_mem_arbiter_if.sv | 29 ++
 rtl/cache_mem_arb_rr_picker.sv | 28 ++
 rtl/cache_mem_arbiter.sv | 94 +++++++++
 4 files changed

// File: rtl/cache_mem_arb_pkg.sv
// rtl/cache_mem_arb_pkg.sv - shared types and constants for the cache/memory arbiter
package cache_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam int P_REQ_NBITS  = 175;
  localparam int P_RESP_NBITS = 145;

  localparam logic REQ_ICACHE = 1'b0;
  localparam logic REQ_DCACHE = 1'b1;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// rtl/cache_mem_arbiter_if.sv - requester-side and memory-side handshake bundle
interface cache_mem_arbiter_if #(
  parameter int p_req_nbits  = 175,
  parameter int p_resp_nbits = 145
);
  logic [1:0]               req_val;
  logic [1:0]               req_rdy;
  logic [2*p_req_nbits-1:0] req_msg;
  logic [1:0]               resp_val;
  logic [1:0]               resp_rdy;
  logic [p_resp_nbits-1:0]  resp_msg;
  logic                     memreq_val;
  logic                     memreq_rdy;
  logic [p_req_nbits-1:0]   memreq_msg;
  logic                     memresp_val;
  logic                     memresp_rdy;
  logic [p_resp_nbits-1:0]  memresp_msg;

  // master is the arbiter; slave is the caches plus memory around it
  modport master (
    input  req_val, req_msg, resp_rdy, memreq_rdy, memresp_val, memresp_msg,
    output req_rdy, resp_val, resp_msg, memreq_val, memreq_msg, memresp_rdy
  );

  modport slave (
    output req_val, req_msg, resp_rdy, memreq_rdy, memresp_val, memresp_msg,
    input  req_rdy, resp_val, resp_msg, memreq_val, memreq_msg, memresp_rdy
  );
endinterface

// File: rtl/cache_mem_arb_rr_picker.sv
// rtl/cache_mem_arb_rr_picker.sv - combinational 2-way picker
// CACHE_MEM_ARB_FIXED_PRIO_EN makes requester 0 always win and ignores last.
import cache_mem_arb_pkg::*;

module cache_mem_arb_rr_picker (
  input  logic [1:0] req_val,
  input  logic       last,
  output logic       gnt_val,
  output logic       gnt_idx
);

`ifdef CACHE_MEM_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = last;

  always_comb begin
    gnt_val = |req_val;
    gnt_idx = req_val[REQ_ICACHE] ? REQ_ICACHE : REQ_DCACHE;
  end
`else
  always_comb begin
    gnt_val = |req_val;
    if (&req_val) gnt_idx = ~last;
    else          gnt_idx = req_val[REQ_DCACHE];
  end
`endif

endmodule

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - one-in-flight arbiter sharing a memory port between icache and dcache
// CACHE_MEM_ARB_FIXED_PRIO_EN selects fixed priority (requester 0) instead of round-robin.
import cache_mem_arb_pkg::*;

module cache_mem_arbiter #(
  parameter int p_req_nbits  = P_REQ_NBITS,
  parameter int p_resp_nbits = P_RESP_NBITS
) (
  input  logic                       clk,
  input  logic                       reset,
  cache_mem_arbiter_if.master        bus,
  output logic                       busy,
  output logic                       owner
);

  state_t                  state, state_next;
  logic [p_req_nbits-1:0]  req_reg;
  logic [p_resp_nbits-1:0] resp_reg;
  logic                    owner_q;
  logic                    last_q;
  logic                    gnt_val, gnt_idx;
  logic                    grant;

  cache_mem_arb_rr_picker picker (
    .req_val (bus.req_val),
    .last    (last_q),
    .gnt_val (gnt_val),
    .gnt_idx (gnt_idx)
  );

  assign grant = (state == IDLE) && gnt_val;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (gnt_val)              state_next = SEND;
      SEND: if (bus.memreq_rdy)       state_next = WAIT;
      WAIT: if (bus.memresp_val)      state_next = RESP;
      RESP: if (bus.resp_rdy[owner_q]) state_next = IDLE;
      default:                        state_next = IDLE;
    endcase
  end

  // Only req_rdy depends combinationally on an input; everything else is state or registers.
  always_comb begin
    bus.req_rdy     = 2'b00;
    bus.memreq_val  = 1'b0;
    bus.memresp_rdy = 1'b0;
    bus.resp_val    = 2'b00;
    case (state)
      IDLE: if (gnt_val) bus.req_rdy = {gnt_idx, ~gnt_idx};
      SEND: bus.memreq_val = 1'b1;
      WAIT: bus.memresp_rdy = 1'b1;
      RESP: bus.resp_val = {owner_q, ~owner_q};
      default: ;
    endcase
  end

  assign bus.memreq_msg = req_reg;
  assign bus.resp_msg   = resp_reg;
  assign busy           = (state != IDLE);
  assign owner          = owner_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      req_reg  <= '0;
      resp_reg <= '0;
      owner_q  <= REQ_ICACHE;
    end else begin
      if (grant) begin
        req_reg <= gnt_idx ? bus.req_msg[2*p_req_nbits-1:p_req_nbits]
                           : bus.req_msg[p_req_nbits-1:0];
        owner_q <= gnt_idx;
      end
      if ((state == WAIT) && bus.memresp_val) resp_reg <= bus.memresp_msg;
    end
  end

`ifdef CACHE_MEM_ARB_FIXED_PRIO_EN
  assign last_q = REQ_DCACHE;
`else
  // Reset to requester 1 so requester 0 gets first priority.
  always_ff @(posedge clk) begin
    if (reset)      last_q <= REQ_DCACHE;
    else if (grant) last_q <= gnt_idx;
  end
`endif

endmodule
